// File: rtl/skid_reg.sv
// Two-entry skid buffer: registered valid/ready on both sides, one beat per cycle
// at full throughput, feeding an enable/data/clear register stage downstream.
module skid_reg #(
  parameter int                 DATA_W  = 8,
  parameter logic [DATA_W-1:0]  RST_VAL = {DATA_W{1'b0}}
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [DATA_W-1:0] s_data_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic [1:0]        count_o
);

  // Handshake: a beat moves on a rising edge when valid and ready are both high
  // in the preceding cycle; valid never waits on ready, and while m_valid_o is
  // high without m_ready_i the m_* outputs hold steady. Ready is never derived
  // combinationally from the opposite side.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;
  logic [DATA_W-1:0] w_main_nxt;
  logic [DATA_W-1:0] w_skid_nxt;
  logic              w_main_full;
  logic              w_skid_full;
  logic              w_in_fire;
  logic              w_out_fire;

  // State and data registers
  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      r_state <= ST_EMPTY;
      r_main  <= RST_VAL;
      r_skid  <= RST_VAL;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

  // Next state; en_i low leaves everything at its current value
  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (en_i) begin
      if (clr_i) begin
        w_state_nxt = ST_EMPTY;
        w_main_nxt  = RST_VAL;
        w_skid_nxt  = RST_VAL;
      end else begin
        case (r_state)
          ST_EMPTY: begin
            if (w_in_fire) begin
              w_main_nxt  = s_data_i;
              w_state_nxt = ST_ONE;
            end
          end
          ST_ONE: begin
            if (w_in_fire && w_out_fire) begin
              w_main_nxt = s_data_i;
            end else if (w_in_fire) begin
              w_skid_nxt  = s_data_i;
              w_state_nxt = ST_TWO;
            end else if (w_out_fire) begin
              w_state_nxt = ST_EMPTY;
            end
          end
          ST_TWO: begin
            if (w_out_fire) begin
              w_main_nxt  = r_skid;
              w_state_nxt = ST_ONE;
            end
          end
          default: begin
            w_state_nxt = ST_EMPTY;
          end
        endcase
      end
    end
  end

  // Outputs depend only on registers and en_i
  always_comb begin
    w_main_full = (r_state == ST_ONE) || (r_state == ST_TWO);
    w_skid_full = (r_state == ST_TWO);
    m_valid_o   = w_main_full & en_i;
    m_data_o    = r_main;
    s_ready_o   = ~w_skid_full & en_i;
    count_o     = {1'b0, w_main_full} + {1'b0, w_skid_full};
    w_in_fire   = s_valid_i & s_ready_o;
    w_out_fire  = m_valid_o & m_ready_i;
  end

endmodule

// File: tb/tb_skid_reg.sv
// Bench for skid_reg: directed steps plus a random tail, with an occupancy/order
// reference queue fed from the stimulus side and checked at every falling edge.
module tb_skid_reg;

  localparam int DATA_W = 8;
  localparam logic [DATA_W-1:0] RST_VAL = '0;

  logic              clk_i;
  logic              arst_i;
  logic              en_i;
  logic              clr_i;
  logic              s_valid_i;
  logic              s_ready_o;
  logic [DATA_W-1:0] s_data_i;
  logic              m_valid_o;
  logic              m_ready_i;
  logic [DATA_W-1:0] m_data_o;
  logic [1:0]        count_o;

  int checks = 0;
  int errors = 0;
  logic auto_chk = 1'b0;
  logic [DATA_W-1:0] exp_q[$];

  skid_reg #(.DATA_W(DATA_W), .RST_VAL(RST_VAL)) dut (
    .clk_i     (clk_i),
    .arst_i    (arst_i),
    .en_i      (en_i),
    .clr_i     (clr_i),
    .s_valid_i (s_valid_i),
    .s_ready_o (s_ready_o),
    .s_data_i  (s_data_i),
    .m_valid_o (m_valid_o),
    .m_ready_i (m_ready_i),
    .m_data_o  (m_data_o),
    .count_o   (count_o)
  );

  // Clock / reset block
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference: occupancy and ordering derived only from bench-driven inputs
  always @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      exp_q.delete();
    end else if (en_i) begin
      if (clr_i) begin
        exp_q.delete();
      end else begin
        automatic logic do_out = m_ready_i && (exp_q.size() > 0);
        automatic logic do_in  = s_valid_i && (exp_q.size() < 2);
        if (do_out) void'(exp_q.pop_front());
        if (do_in)  exp_q.push_back(s_data_i);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk_i) begin
    if (auto_chk) begin
      chk("count", {30'd0, count_o}, exp_q.size());
      chk("s_ready", {31'd0, s_ready_o}, {31'd0, en_i && (exp_q.size() < 2)});
      chk("m_valid", {31'd0, m_valid_o}, {31'd0, en_i && (exp_q.size() > 0)});
      if (en_i && exp_q.size() > 0)
        chk("m_data", {24'd0, m_data_o}, {24'd0, exp_q[0]});
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic r);
    s_valid_i = v;
    s_data_i  = d;
    m_ready_i = r;
  endtask

  initial begin
    arst_i = 1'b0;
    en_i   = 1'b1;
    clr_i  = 1'b0;
    drive(1'b0, '0, 1'b0);

    // Reset then idle
    repeat (3) @(posedge clk_i);
    #1 arst_i = 1'b1;
    auto_chk = 1'b1;
    @(negedge clk_i);
    chk("rst_m_valid", {31'd0, m_valid_o}, 32'd0);
    chk("rst_count", {30'd0, count_o}, 32'd0);
    chk("rst_s_ready", {31'd0, s_ready_o}, 32'd1);
    chk("rst_m_data", {24'd0, m_data_o}, {24'd0, RST_VAL});

    // Streaming 0x01..0x10 with no backpressure
    step();
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, i[DATA_W-1:0], 1'b1);
      step();
    end
    drive(1'b0, '0, 1'b1);
    @(negedge clk_i);
    chk("stream_last", {24'd0, m_data_o}, 32'h10);
    chk("stream_count", {30'd0, count_o}, 32'd1);
    step();
    step();

    // Backpressure: A3 is held by the producer
    drive(1'b1, 8'hA1, 1'b0); step();
    drive(1'b1, 8'hA2, 1'b0); step();
    drive(1'b1, 8'hA3, 1'b0); step();
    @(negedge clk_i);
    chk("bp_count", {30'd0, count_o}, 32'd2);
    chk("bp_s_ready", {31'd0, s_ready_o}, 32'd0);
    chk("bp_head", {24'd0, m_data_o}, 32'hA1);
    drive(1'b1, 8'hA3, 1'b1); step();
    @(negedge clk_i);
    chk("bp_second", {24'd0, m_data_o}, 32'hA2);
    step();
    drive(1'b0, '0, 1'b1);
    @(negedge clk_i);
    chk("bp_third", {24'd0, m_data_o}, 32'hA3);
    step();
    step();

    // Flush with a competing input beat
    drive(1'b1, 8'h55, 1'b0); step();
    drive(1'b1, 8'h66, 1'b0); step();
    clr_i = 1'b1;
    drive(1'b1, 8'h77, 1'b0); step();
    clr_i = 1'b0;
    drive(1'b0, '0, 1'b1);
    @(negedge clk_i);
    chk("flush_count", {30'd0, count_o}, 32'd0);
    chk("flush_m_valid", {31'd0, m_valid_o}, 32'd0);
    chk("flush_m_data", {24'd0, m_data_o}, {24'd0, RST_VAL});
    step();
    step();

    // Enable gating, including a clear while disabled
    drive(1'b1, 8'h3C, 1'b0); step();
    en_i = 1'b0;
    drive(1'b1, 8'hEE, 1'b1);
    repeat (3) step();
    clr_i = 1'b1; step();
    clr_i = 1'b0;
    @(negedge clk_i);
    chk("gate_count", {30'd0, count_o}, 32'd1);
    chk("gate_s_ready", {31'd0, s_ready_o}, 32'd0);
    chk("gate_m_valid", {31'd0, m_valid_o}, 32'd0);
    en_i = 1'b1;
    drive(1'b0, '0, 1'b1);
    #1;
    chk("gate_release", {24'd0, m_data_o}, 32'h3C);
    step();
    @(negedge clk_i);
    chk("gate_drained", {30'd0, count_o}, 32'd0);

    // Asynchronous reset between edges
    drive(1'b1, 8'h11, 1'b0); step();
    drive(1'b1, 8'h22, 1'b0); step();
    drive(1'b0, '0, 1'b0);
    @(posedge clk_i);
    #3 arst_i = 1'b0;
    #1;
    chk("arst_count", {30'd0, count_o}, 32'd0);
    chk("arst_m_valid", {31'd0, m_valid_o}, 32'd0);
    chk("arst_m_data", {24'd0, m_data_o}, {24'd0, RST_VAL});
    step();
    arst_i = 1'b1;
    step();

    // Random traffic
    for (int i = 0; i < 200; i++) begin
      drive(1'($urandom_range(1, 0)), 8'($urandom_range(255, 0)), 1'($urandom_range(1, 0)));
      en_i  = ($urandom_range(9, 0) != 0);
      clr_i = ($urandom_range(29, 0) == 0);
      step();
    end
    en_i  = 1'b1;
    clr_i = 1'b0;
    drive(1'b0, '0, 1'b1);
    repeat (3) step();
    @(negedge clk_i);
    chk("final_empty", {30'd0, count_o}, 32'd0);

    auto_chk = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
